// File: rtl/fb_pixel_packer_if.sv
// rtl/fb_pixel_packer_if.sv - pixel stream and framebuffer write channel of the pixel packer
interface fb_pixel_packer_if;
    logic        pix_valid;
    logic        pix_ready;
    logic [18:0] px;
    logic [7:0]  pix_color;
    logic        frame;
    logic [28:0] fb_addr;
    logic [63:0] fb_data;
    logic        fb_req;
    logic        fb_ready;
    logic        busy;
    logic [7:0]  drop_cnt;

    // Environment side: renderer pixel source plus ddram write sink
    modport master (
        output pix_valid, px, pix_color, frame, fb_ready,
        input  pix_ready, fb_addr, fb_data, fb_req, busy, drop_cnt
    );

    // Packer side
    modport slave (
        input  pix_valid, px, pix_color, frame, fb_ready,
        output pix_ready, fb_addr, fb_data, fb_req, busy, drop_cnt
    );
endinterface

// File: rtl/fb_pixel_packer.sv
// rtl/fb_pixel_packer.sv - packs 8-bit pixels into 64-bit framebuffer words and writes them to ddram
module fb_pixel_packer #(
    parameter logic [28:0] FB_BASE = 29'h1000_0000,
    parameter int unsigned NPIX    = 345600
) (
    input  logic              clk_sys,
    input  logic              reset,
    fb_pixel_packer_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;

    // Word assembler
    logic [63:0] word_buf;
    logic [7:0]  lane_mask;
    logic [15:0] cur_widx;
    logic [7:0]  drop_cnt_q;

    // Word FIFO
    logic [15:0] fifo_widx [4];
    logic [63:0] fifo_data [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;
    logic        pending;

    // Output request channel
    state_t      state;
    logic        fb_req_q;
    logic [28:0] fb_addr_q;
    logic [63:0] fb_data_q;

    // Next-state of the assembler
    logic        pix_ready_int;
    logic        pix_acc;
    logic        pix_drop;
    logic        pix_wr;
    logic [15:0] pix_widx;
    logic [2:0]  pix_lane;
    logic        push_a;
    logic        push_b;
    logic        pop;
    logic [1:0]  wr_ptr_b;
    logic [63:0] base_buf;
    logic [7:0]  base_mask;
    logic [63:0] new_buf;
    logic [7:0]  new_mask;
    logic [63:0] nxt_buf;
    logic [7:0]  nxt_mask;
    logic [15:0] nxt_widx;

    // Room for two pushes is guaranteed whenever a pixel is accepted
    assign pix_ready_int = ~reset & (count <= 3'd2);

    // Pixel acceptance, flush decisions and the assembler's next contents
    always_comb begin
        pix_acc   = bus.pix_valid & pix_ready_int;
        pix_drop  = pix_acc & ({13'd0, bus.px} >= NPIX);
        pix_wr    = pix_acc & ~pix_drop;
        pix_widx  = bus.px[18:3];
        pix_lane  = bus.px[2:0];

        // First push: frame flush or jump to another word; both push the old word
        push_a    = (lane_mask != 8'd0) & (bus.frame | (pix_wr & (pix_widx != cur_widx)));
        base_buf  = push_a ? 64'd0 : word_buf;
        base_mask = push_a ? 8'd0  : lane_mask;

        new_buf   = base_buf;
        new_buf[{pix_lane, 3'b000} +: 8] = bus.pix_color;
        new_mask  = base_mask | (8'd1 << pix_lane);

        // Second push: the pixel landed in the last lane of its word
        push_b    = pix_wr & (pix_lane == 3'd7);

        nxt_buf   = base_buf;
        nxt_mask  = base_mask;
        nxt_widx  = cur_widx;
        if (pix_wr) begin
            nxt_widx = pix_widx;
            if (push_b) begin
                nxt_buf  = 64'd0;
                nxt_mask = 8'd0;
            end else begin
                nxt_buf  = new_buf;
                nxt_mask = new_mask;
            end
        end

        wr_ptr_b  = wr_ptr + {1'b0, push_a};
        pop       = (state == S_REQ) & bus.fb_ready;
    end

    // Assembler registers and dropped-pixel counter; word_buf keeps unset lanes at zero
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            word_buf   <= 64'd0;
            lane_mask  <= 8'd0;
            cur_widx   <= 16'd0;
            drop_cnt_q <= 8'd0;
        end else begin
            word_buf  <= nxt_buf;
            lane_mask <= nxt_mask;
            cur_widx  <= nxt_widx;
            if (pix_drop && drop_cnt_q != 8'hFF) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end
    end

    // Four-entry in-order word FIFO, up to two pushes and one pop per cycle
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr  <= 2'd0;
            rd_ptr  <= 2'd0;
            count   <= 3'd0;
            pending <= 1'b0;
        end else begin
            if (push_a) begin
                fifo_widx[wr_ptr] <= cur_widx;
                fifo_data[wr_ptr] <= word_buf;
            end
            if (push_b) begin
                fifo_widx[wr_ptr_b] <= pix_widx;
                fifo_data[wr_ptr_b] <= new_buf;
            end
            wr_ptr <= wr_ptr + {1'b0, push_a} + {1'b0, push_b};
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            count   <= count + {2'd0, push_a} + {2'd0, push_b} - {2'd0, pop};
            // Registered non-empty flag: one stage between the pixel path and the request
            // launch; its one-cycle lag after a pop is covered by the GAP state
            pending <= (count != 3'd0);
        end
    end

    // Request FSM: launch the FIFO head, hold it until ddram completes, then one idle gap
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= S_IDLE;
            fb_req_q  <= 1'b0;
            fb_addr_q <= 29'd0;
            fb_data_q <= 64'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pending) begin
                        fb_addr_q <= FB_BASE + {10'd0, fifo_widx[rd_ptr], 3'b000};
                        fb_data_q <= fifo_data[rd_ptr];
                        fb_req_q  <= 1'b1;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.fb_ready) begin
                        fb_req_q <= 1'b0;
                        state    <= S_GAP;
                    end
                end
                S_GAP: begin
                    state <= S_IDLE;
                end
                default: begin
                    fb_req_q <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.pix_ready = pix_ready_int;
    assign bus.fb_req    = fb_req_q;
    assign bus.fb_addr   = fb_addr_q;
    assign bus.fb_data   = fb_data_q;
    assign bus.drop_cnt  = drop_cnt_q;
    assign bus.busy      = (lane_mask != 8'd0) | (count != 3'd0) | (state != S_IDLE);

endmodule

// File: doc/fb_pixel_packer.md
# fb_pixel_packer

Packs the renderer's 8-bit indexed pixel stream into 64-bit framebuffer words and issues them as writes to the DDRAM framebuffer channel (ch1). Sits between `renderer` (pixel producer) and `ddram` (word consumer) in the `emu` top. Decouples renderer pixel timing from DDRAM latency with a 4-entry word FIFO and flushes partial words on frame boundaries and non-sequential pixel jumps.

## Interface
Parameters:
- `FB_BASE`, 29'h1000_0000, byte address of framebuffer pixel 0 (8-byte aligned)
- `NPIX`, 345600, pixels per frame (720x480); indices >= NPIX are dropped

Ports:
- `clk_sys`  in  1  system clock; sole clock
- `reset`  in  1  synchronous, active-high reset
- `pix_valid`  in  1  pixel present on `px`/`pix_color`
- `pix_ready`  out  1  pixel accepted on edge where `pix_valid & pix_ready`
- `px`  in  19  linear pixel index
- `pix_color`  in  8  palette index
- `frame`  in  1  one-cycle start-of-frame pulse; flushes partial word
- `fb_addr`  out  29  write byte address
- `fb_data`  out  64  write data; pixel lane n at bits [8n+7:8n]
- `fb_req`  out  1  write request, held until `fb_ready`
- `fb_ready`  in  1  one-cycle completion pulse from ddram
- `busy`  out  1  partial word, FIFO entry or request outstanding
- `drop_cnt`  out  8  saturating count of dropped pixels

## Operation
- Assembler: `word_buf[63:0]`, `lane_mask[7:0]`, `cur_widx[15:0]`. Accepted pixel: widx = px[18:3], lane = px[2:0].
- px >= NPIX: accepted, discarded, `drop_cnt` += 1, saturating at 255; assembler untouched.
- Flush rule: if `lane_mask != 0` and widx != cur_widx, push current word (unwritten lanes = 8'h00), then start new word with this pixel.
- Pixel written into its lane; `lane_mask[lane]` set; rewriting a set lane overwrites it.
- If lane == 7 after write, push word and clear `lane_mask`.
- `frame` with `lane_mask != 0`: push partial word. Same-cycle `frame` + pixel: flush occurs first; pixel starts new word (may also push if lane 7) — up to 2 pushes per cycle.
- `frame` with empty assembler: no push.
- Push entry = {widx, data}; FIFO depth 4, in-order. `pix_ready = ~reset & (count <= 2)`, count is registered occupancy (pushes and pop in same cycle allowed).
- Output FSM: IDLE -> REQ when FIFO non-empty: load `fb_addr = FB_BASE + {widx,3'b000}`, `fb_data`, raise `fb_req`. REQ -> GAP on `fb_ready`: pop FIFO, drop `fb_req`. GAP -> IDLE after one cycle (mandatory one-cycle low between requests).
- `fb_addr`/`fb_data` stable while `fb_req` high. `fb_ready` ignored outside REQ.
- `busy = (lane_mask != 0) | (count != 0) | (state != IDLE)`.

## Timing
- Reset values: `pix_ready` 0, `fb_req` 0, `fb_addr` 0, `fb_data` 0, `busy` 0, `drop_cnt` 0; FIFO, `lane_mask`, state cleared. `pix_ready` 1 on first cycle after reset deasserts.
- Reset mid-request: `fb_req` low after the reset edge; a later `fb_ready` is ignored; no entries survive.
- Latency: pixel completing a word accepted at edge E -> entry in FIFO after E -> `fb_req` high after edge E+2 (FIFO empty, state IDLE).
- `fb_ready` sampled at edge T -> `fb_req` low after T -> next `fb_req` high after T+2 at the earliest.
- Throughput: one word per (ddram latency + 2) cycles; sustained renderer rate limited by backpressure only.
- Address arithmetic 29-bit unsigned, wraps modulo 2^29.

## Test plan
- px 0..7, colors 0x10..0x17 -> one write, `fb_addr`=FB_BASE, `fb_data`=64'h1716151413121110, `fb_req` high 2 cycles after last accept.
- px 8..10 color 0xAA, then `frame` -> write `fb_addr`=FB_BASE+8, `fb_data`=64'h0000000000AAAAAA; `busy` 0 after `fb_ready`+1.
- px 16 (0x05) then px 40 (0x06), then `frame` -> writes FB_BASE+16 data 64'h05, then FB_BASE+40 data 64'h06, in order.
- `fb_ready` held 0, stream px 0..39 -> `pix_ready` drops once 3 words queued, no loss; pulse `fb_ready` 5 times -> 5 words FB_BASE..FB_BASE+32 in order, each with one-cycle `fb_req` gap.
- px 345600 -> no write, `drop_cnt`=1; 300 such pixels -> `drop_cnt`=255.
- `reset` pulse while `fb_req` high -> `fb_req`=0 next cycle, subsequent `fb_ready` produces no pop, `busy`=0, `drop_cnt`=0.
